// File: rtl/vram_arb_pkg.sv
// rtl/vram_arb_pkg.sv - shared types and default widths for the VRAM arbiter
package vram_arb_pkg;

    localparam int VRAM_AW = 11;
    localparam int VRAM_DW = 8;

    // CPU access sequencer states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_ACK     = 2'd2
    } cpu_state_t;

    // Owner of a RAM read slot travelling alongside the read latency
    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_DISP = 2'd1,
        TAG_CPU  = 2'd2
    } tag_t;

endpackage

// File: rtl/vram_arbiter_if.sv
// rtl/vram_arbiter_if.sv - display, CPU and RAM-side signal bundle of the VRAM arbiter
interface vram_arbiter_if
    import vram_arb_pkg::*;
#(
    parameter int AW = VRAM_AW,
    parameter int DW = VRAM_DW
) ();

    logic          disp_req;
    logic [AW-1:0] disp_addr;
    logic [DW-1:0] disp_data;
    logic          disp_valid;

    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_ack;

    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    logic          starved;
    logic          starve_clr;

    // Arbiter side
    modport slave (
        input  disp_req, disp_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata,
               ram_rdata, starve_clr,
        output disp_data, disp_valid, cpu_rdata, cpu_ack,
               ram_addr, ram_we, ram_wdata, starved
    );

    // Requester / RAM side
    modport master (
        output disp_req, disp_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata,
               ram_rdata, starve_clr,
        input  disp_data, disp_valid, cpu_rdata, cpu_ack,
               ram_addr, ram_we, ram_wdata, starved
    );

endinterface

// File: rtl/vram_tag_pipe.sv
// rtl/vram_tag_pipe.sv - shift register tracking which requester owns each in-flight read
module vram_tag_pipe
    import vram_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic CLK,
    input  logic reset,
    input  tag_t tag_in,
    output tag_t tag_out
);

    tag_t stages [DEPTH];

    // Advance one stage per clock; reset drops every in-flight read
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stages[i] <= TAG_NONE;
            end
        end else begin
            stages[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign tag_out = stages[DEPTH-1];

endmodule

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - single-port VRAM arbiter, display fetch has absolute priority over the CPU
module vram_arbiter
    import vram_arb_pkg::*;
#(
    parameter int AW       = VRAM_AW,
    parameter int DW       = VRAM_DW,
    parameter int RD_LAT   = 1,
    parameter int MAX_WAIT = 255
) (
    input  logic           CLK,
    input  logic           reset,
    vram_arbiter_if.slave  bus
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    cpu_state_t state, state_nxt;

    logic disp_grant;
    logic cpu_grant;
    tag_t tag_in;
    tag_t tag_out;

    logic [AW-1:0]     ram_addr_q;
    logic              ram_we_q;
    logic [DW-1:0]     ram_wdata_q;
    logic [DW-1:0]     disp_data_q;
    logic              disp_valid_q;
    logic [DW-1:0]     cpu_rdata_q;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic              starve_set;
    logic              starved_q;

    // The CPU only gets a slot the display left free, and only from IDLE
    assign disp_grant = bus.disp_req;
    assign cpu_grant  = !bus.disp_req && (state == ST_IDLE) && bus.cpu_req;

    // Tag issued with each slot; CPU writes return nothing so they carry no tag
    always_comb begin
        tag_in = TAG_NONE;
        if (disp_grant) begin
            tag_in = TAG_DISP;
        end else if (cpu_grant && !bus.cpu_we) begin
            tag_in = TAG_CPU;
        end
    end

    vram_tag_pipe #(
        .DEPTH (RD_LAT + 1)
    ) u_tag_pipe (
        .CLK     (CLK),
        .reset   (reset),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    // CPU sequencer next state: write acks straight away, read waits for its tag to return
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (cpu_grant) begin
                    state_nxt = bus.cpu_we ? ST_ACK : ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (tag_out == TAG_CPU) begin
                    state_nxt = ST_ACK;
                end
            end
            ST_ACK: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // CPU sequencer state register
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Registered RAM port; address and write data hold when nobody owns the slot
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            ram_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_wdata_q <= '0;
        end else if (disp_grant) begin
            ram_addr_q <= bus.disp_addr;
            ram_we_q   <= 1'b0;
        end else if (cpu_grant) begin
            ram_addr_q  <= bus.cpu_addr;
            ram_we_q    <= bus.cpu_we;
            ram_wdata_q <= bus.cpu_wdata;
        end else begin
            ram_we_q <= 1'b0;
        end
    end

    // Steer returning read data to its owner using the tag leaving the pipe
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            disp_data_q  <= '0;
            disp_valid_q <= 1'b0;
            cpu_rdata_q  <= '0;
        end else begin
            disp_valid_q <= (tag_out == TAG_DISP);
            if (tag_out == TAG_DISP) begin
                disp_data_q <= bus.ram_rdata;
            end
            if (tag_out == TAG_CPU) begin
                cpu_rdata_q <= bus.ram_rdata;
            end
        end
    end

    // Count slots the CPU lost to the display while it was ready to go
    always_comb begin
        wait_cnt_nxt = wait_cnt;
        if (!bus.cpu_req || cpu_grant) begin
            wait_cnt_nxt = '0;
        end else if ((state == ST_IDLE) && bus.disp_req && (wait_cnt != WAIT_MAX)) begin
            wait_cnt_nxt = wait_cnt + 1'b1;
        end
    end

    assign starve_set = (wait_cnt_nxt == WAIT_MAX);

    // Wait counter and sticky starvation flag; a set on the same edge beats a clear
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            wait_cnt  <= '0;
            starved_q <= 1'b0;
        end else begin
            wait_cnt <= wait_cnt_nxt;
            if (starve_set) begin
                starved_q <= 1'b1;
            end else if (bus.starve_clr) begin
                starved_q <= 1'b0;
            end
        end
    end

    assign bus.ram_addr   = ram_addr_q;
    assign bus.ram_we     = ram_we_q;
    assign bus.ram_wdata  = ram_wdata_q;
    assign bus.disp_data  = disp_data_q;
    assign bus.disp_valid = disp_valid_q;
    assign bus.cpu_rdata  = cpu_rdata_q;
    assign bus.cpu_ack    = (state == ST_ACK);
    assign bus.starved    = starved_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - directed self-checking bench for vram_arbiter
module tb_vram_arbiter;

    logic CLK = 1'b0;
    logic reset;
    int   checks;
    int   errors;

    always #5 CLK = ~CLK;

    vram_arbiter_if #(.AW(11), .DW(8)) bus ();

    vram_arbiter #(
        .AW       (11),
        .DW       (8),
        .RD_LAT   (1),
        .MAX_WAIT (4)
    ) dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus)
    );

    // Synchronous single-port RAM, one cycle read latency, plus a preload port
    logic [7:0]  mem [2048];
    logic [7:0]  rd_q;
    logic        pre_we;
    logic [10:0] pre_addr;
    logic [7:0]  pre_data;

    always @(posedge CLK) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
        rd_q <= mem[bus.ram_addr];
    end

    assign bus.ram_rdata = rd_q;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic preload(input logic [10:0] a, input logic [7:0] d);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_data = d;
        tick();
        pre_we   = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        preload(11'h010, 8'hA5);
        preload(11'h005, 8'h55);
        preload(11'h006, 8'h66);
        checks++; if (bus.disp_valid !== 1'b0) begin errors++; $display("FAIL reset_disp_valid: got %b expected 0", bus.disp_valid); end
        checks++; if (bus.disp_data !== 8'h00) begin errors++; $display("FAIL reset_disp_data: got %h expected 00", bus.disp_data); end
        checks++; if (bus.cpu_ack !== 1'b0) begin errors++; $display("FAIL reset_cpu_ack: got %b expected 0", bus.cpu_ack); end
        checks++; if (bus.cpu_rdata !== 8'h00) begin errors++; $display("FAIL reset_cpu_rdata: got %h expected 00", bus.cpu_rdata); end
        checks++; if (bus.ram_addr !== 11'h000) begin errors++; $display("FAIL reset_ram_addr: got %h expected 000", bus.ram_addr); end
        checks++; if (bus.ram_we !== 1'b0) begin errors++; $display("FAIL reset_ram_we: got %b expected 0", bus.ram_we); end
        checks++; if (bus.ram_wdata !== 8'h00) begin errors++; $display("FAIL reset_ram_wdata: got %h expected 00", bus.ram_wdata); end
        checks++; if (bus.starved !== 1'b0) begin errors++; $display("FAIL reset_starved: got %b expected 0", bus.starved); end
        reset = 1'b0;
        tick();
        checks++; if (bus.cpu_ack !== 1'b0 || bus.disp_valid !== 1'b0) begin errors++; $display("FAIL post_reset_idle: ack %b valid %b expected 0 0", bus.cpu_ack, bus.disp_valid); end
    endtask

    task automatic test_disp_fetch();
        bus.disp_req  = 1'b1;
        bus.disp_addr = 11'h010;
        tick();
        bus.disp_req = 1'b0;
        checks++; if (bus.ram_addr !== 11'h010 || bus.ram_we !== 1'b0) begin errors++; $display("FAIL disp_slot: addr %h we %b expected 010 0", bus.ram_addr, bus.ram_we); end
        tick();
        checks++; if (bus.disp_valid !== 1'b0) begin errors++; $display("FAIL disp_early: valid %b expected 0", bus.disp_valid); end
        tick();
        checks++; if (bus.disp_valid !== 1'b1 || bus.disp_data !== 8'hA5) begin errors++; $display("FAIL disp_data: valid %b data %h expected 1 a5", bus.disp_valid, bus.disp_data); end
        checks++; if (bus.cpu_ack !== 1'b0) begin errors++; $display("FAIL disp_no_ack: ack %b expected 0", bus.cpu_ack); end
        tick();
        checks++; if (bus.disp_valid !== 1'b0 || bus.disp_data !== 8'hA5) begin errors++; $display("FAIL disp_hold: valid %b data %h expected 0 a5", bus.disp_valid, bus.disp_data); end
    endtask

    task automatic test_cpu_write_read();
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = 11'h123;
        bus.cpu_wdata = 8'h3C;
        tick();
        checks++; if (bus.ram_we !== 1'b1 || bus.ram_addr !== 11'h123 || bus.ram_wdata !== 8'h3C) begin errors++; $display("FAIL wr_slot: we %b addr %h data %h expected 1 123 3c", bus.ram_we, bus.ram_addr, bus.ram_wdata); end
        checks++; if (bus.cpu_ack !== 1'b1) begin errors++; $display("FAIL wr_ack: ack %b expected 1", bus.cpu_ack); end
        bus.cpu_req = 1'b0;
        tick();
        checks++; if (bus.cpu_ack !== 1'b0 || bus.ram_we !== 1'b0) begin errors++; $display("FAIL wr_done: ack %b we %b expected 0 0", bus.cpu_ack, bus.ram_we); end
        bus.cpu_req = 1'b1;
        bus.cpu_we  = 1'b0;
        tick();
        checks++; if (bus.cpu_ack !== 1'b0 || bus.ram_addr !== 11'h123) begin errors++; $display("FAIL rd_slot: ack %b addr %h expected 0 123", bus.cpu_ack, bus.ram_addr); end
        tick();
        checks++; if (bus.cpu_ack !== 1'b0) begin errors++; $display("FAIL rd_early: ack %b expected 0", bus.cpu_ack); end
        tick();
        checks++; if (bus.cpu_ack !== 1'b1 || bus.cpu_rdata !== 8'h3C) begin errors++; $display("FAIL rd_data: ack %b data %h expected 1 3c", bus.cpu_ack, bus.cpu_rdata); end
        bus.cpu_req = 1'b0;
        tick();
        checks++; if (bus.cpu_ack !== 1'b0) begin errors++; $display("FAIL rd_ack_pulse: ack %b expected 0", bus.cpu_ack); end
    endtask

    task automatic test_contention();
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = 11'h005;
        bus.disp_req  = 1'b1;
        bus.disp_addr = 11'h006;
        tick();
        bus.disp_req = 1'b0;
        checks++; if (bus.ram_addr !== 11'h006) begin errors++; $display("FAIL cont_disp_first: addr %h expected 006", bus.ram_addr); end
        tick();
        checks++; if (bus.ram_addr !== 11'h005 || bus.disp_valid !== 1'b0) begin errors++; $display("FAIL cont_cpu_slot: addr %h valid %b expected 005 0", bus.ram_addr, bus.disp_valid); end
        tick();
        checks++; if (bus.disp_valid !== 1'b1 || bus.disp_data !== 8'h66 || bus.cpu_ack !== 1'b0) begin errors++; $display("FAIL cont_disp_data: valid %b data %h ack %b expected 1 66 0", bus.disp_valid, bus.disp_data, bus.cpu_ack); end
        tick();
        checks++; if (bus.cpu_ack !== 1'b1 || bus.cpu_rdata !== 8'h55 || bus.disp_valid !== 1'b0) begin errors++; $display("FAIL cont_cpu_data: ack %b data %h valid %b expected 1 55 0", bus.cpu_ack, bus.cpu_rdata, bus.disp_valid); end
        bus.cpu_req = 1'b0;
        tick();
    endtask

    task automatic test_starvation();
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = 11'h200;
        bus.cpu_wdata = 8'h77;
        bus.disp_req  = 1'b1;
        bus.disp_addr = 11'h010;
        for (int i = 0; i < 6; i++) begin
            if (i == 5) bus.starve_clr = 1'b1;
            tick();
            checks++; if (bus.ram_we !== 1'b0 || bus.cpu_ack !== 1'b0) begin errors++; $display("FAIL starve_blocked_%0d: we %b ack %b expected 0 0", i, bus.ram_we, bus.cpu_ack); end
            if (i == 2) begin
                checks++; if (bus.starved !== 1'b0) begin errors++; $display("FAIL starve_early: starved %b expected 0", bus.starved); end
            end
            if (i == 4) begin
                checks++; if (bus.starved !== 1'b1) begin errors++; $display("FAIL starve_set: starved %b expected 1", bus.starved); end
            end
        end
        checks++; if (bus.starved !== 1'b1) begin errors++; $display("FAIL starve_set_wins: starved %b expected 1", bus.starved); end
        bus.disp_req   = 1'b0;
        bus.starve_clr = 1'b0;
        tick();
        checks++; if (bus.ram_we !== 1'b1 || bus.ram_addr !== 11'h200 || bus.ram_wdata !== 8'h77 || bus.cpu_ack !== 1'b1) begin errors++; $display("FAIL starve_cpu_done: we %b addr %h data %h ack %b expected 1 200 77 1", bus.ram_we, bus.ram_addr, bus.ram_wdata, bus.cpu_ack); end
        bus.cpu_req    = 1'b0;
        bus.starve_clr = 1'b1;
        tick();
        bus.starve_clr = 1'b0;
        checks++; if (bus.starved !== 1'b0) begin errors++; $display("FAIL starve_clr: starved %b expected 0", bus.starved); end
        tick();
    endtask

    task automatic test_reset_mid();
        bus.disp_req  = 1'b1;
        bus.disp_addr = 11'h010;
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = 11'h123;
        tick();
        bus.disp_req = 1'b0;
        tick();
        checks++; if (bus.ram_addr !== 11'h123) begin errors++; $display("FAIL mid_pre_reset: addr %h expected 123", bus.ram_addr); end
        #2;
        reset = 1'b1;
        bus.cpu_req = 1'b0;
        #1;
        checks++; if (bus.ram_addr !== 11'h000 || bus.ram_we !== 1'b0 || bus.ram_wdata !== 8'h00) begin errors++; $display("FAIL mid_ram_port: addr %h we %b data %h expected 000 0 00", bus.ram_addr, bus.ram_we, bus.ram_wdata); end
        checks++; if (bus.disp_data !== 8'h00 || bus.cpu_rdata !== 8'h00 || bus.cpu_ack !== 1'b0 || bus.disp_valid !== 1'b0) begin errors++; $display("FAIL mid_outputs: ddata %h crdata %h ack %b valid %b expected 00 00 0 0", bus.disp_data, bus.cpu_rdata, bus.cpu_ack, bus.disp_valid); end
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (bus.cpu_ack !== 1'b0 || bus.disp_valid !== 1'b0) begin errors++; $display("FAIL mid_quiet_%0d: ack %b valid %b expected 0 0", i, bus.cpu_ack, bus.disp_valid); end
        end
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 11'h005;
        tick();
        tick();
        tick();
        checks++; if (bus.cpu_ack !== 1'b1 || bus.cpu_rdata !== 8'h55) begin errors++; $display("FAIL mid_new_read: ack %b data %h expected 1 55", bus.cpu_ack, bus.cpu_rdata); end
        bus.cpu_req = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [10:0] addrs [4];
        logic [7:0]  exp_d [4];
        addrs[0] = 11'h005; exp_d[0] = 8'h55;
        addrs[1] = 11'h006; exp_d[1] = 8'h66;
        addrs[2] = 11'h010; exp_d[2] = 8'hA5;
        addrs[3] = 11'h123; exp_d[3] = 8'h3C;

        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = 11'h300;
        bus.cpu_wdata = 8'h11;
        tick();
        checks++; if (bus.ram_we !== 1'b1 || bus.cpu_ack !== 1'b1) begin errors++; $display("FAIL b2b_first: we %b ack %b expected 1 1", bus.ram_we, bus.cpu_ack); end
        tick();
        checks++; if (bus.ram_we !== 1'b0 || bus.cpu_ack !== 1'b0) begin errors++; $display("FAIL b2b_gap: we %b ack %b expected 0 0", bus.ram_we, bus.cpu_ack); end
        bus.cpu_wdata = 8'h22;
        tick();
        checks++; if (bus.ram_we !== 1'b1 || bus.ram_wdata !== 8'h22 || bus.cpu_ack !== 1'b1) begin errors++; $display("FAIL b2b_second: we %b data %h ack %b expected 1 22 1", bus.ram_we, bus.ram_wdata, bus.cpu_ack); end
        bus.cpu_req = 1'b0;
        tick();
        checks++; if (bus.ram_we !== 1'b0) begin errors++; $display("FAIL b2b_release: we %b expected 0", bus.ram_we); end

        for (int i = 0; i < 7; i++) begin
            if (i < 4) begin
                bus.disp_req  = 1'b1;
                bus.disp_addr = addrs[i];
            end else begin
                bus.disp_req = 1'b0;
            end
            tick();
            if (i >= 2 && i < 6) begin
                checks++; if (bus.disp_valid !== 1'b1 || bus.disp_data !== exp_d[i-2]) begin errors++; $display("FAIL b2b_disp_%0d: valid %b data %h expected 1 %h", i - 2, bus.disp_valid, bus.disp_data, exp_d[i-2]); end
            end
            if (i == 6) begin
                checks++; if (bus.disp_valid !== 1'b0) begin errors++; $display("FAIL b2b_disp_end: valid %b expected 0", bus.disp_valid); end
            end
        end
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        reset          = 1'b1;
        pre_we         = 1'b0;
        pre_addr       = '0;
        pre_data       = '0;
        bus.disp_req   = 1'b0;
        bus.disp_addr  = '0;
        bus.cpu_req    = 1'b0;
        bus.cpu_we     = 1'b0;
        bus.cpu_addr   = '0;
        bus.cpu_wdata  = '0;
        bus.starve_clr = 1'b0;

        test_reset();
        test_disp_fetch();
        test_cpu_write_read();
        test_contention();
        test_starvation();
        test_reset_mid();
        test_back_to_back();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
